// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage buffer: control-word layout and state encoding.
package pipe_pkg;

  localparam int CTRL_W = 8;

  localparam int CTRL_RD_RAM  = 0;
  localparam int CTRL_WR_RAM  = 1;
  localparam int CTRL_DEMUX   = 2;
  localparam int CTRL_WR_BR   = 3;
  localparam int CTRL_ALU_LSB = 4;
  localparam int CTRL_ALU_MSB = 7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage buffer: {ctrl, wA, DR1, DR2} with load, clear-ctrl and clear-all.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              clr_all_i,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] dr1_i,
  input  logic [DATA_W-1:0] dr2_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [ADDR_W-1:0] wa_o,
  output logic [DATA_W-1:0] dr1_o,
  output logic [DATA_W-1:0] dr2_o
);
  import pipe_pkg::*;

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] dr1_q, dr1_d;
  logic [DATA_W-1:0] dr2_q, dr2_d;

  // Data fields keep their last value when only the ctrl field is cleared.
  always_comb begin
    ctrl_d = ctrl_q;
    wa_d   = wa_q;
    dr1_d  = dr1_q;
    dr2_d  = dr2_q;
    if (clr_all_i) begin
      ctrl_d = '0;
      wa_d   = '0;
      dr1_d  = '0;
      dr2_d  = '0;
    end else if (load_i) begin
      ctrl_d = ctrl_i;
      wa_d   = wa_i;
      dr1_d  = dr1_i;
      dr2_d  = dr2_i;
    end else if (clr_ctrl_i) begin
      ctrl_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    ctrl_q <= ctrl_d;
    wa_q   <= wa_d;
    dr1_q  <= dr1_d;
    dr2_q  <= dr2_d;
  end

  assign ctrl_o = ctrl_q;
  assign wa_o   = wa_q;
  assign dr1_o  = dr1_q;
  assign dr2_o  = dr2_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional macro PIPE_STAGE_PERF_EN adds stall and bubble counters.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [ADDR_W-1:0] i_wA,
  input  logic [DATA_W-1:0] i_DR1,
  input  logic [DATA_W-1:0] i_DR2,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [ADDR_W-1:0] o_wA,
  output logic [DATA_W-1:0] o_DR1,
  output logic [DATA_W-1:0] o_DR2
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       o_stall_cnt,
  output logic [15:0]       o_bubble_cnt
`endif
);
  import pipe_pkg::*;

  state_e state_q, state_d;
  logic   in_fire, out_fire;
  logic   main_load, main_from_skid, main_clr;
  logic   skid_load, skid_clr;

  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;
  logic [ADDR_W-1:0] skid_wa, main_wa_in;
  logic [DATA_W-1:0] skid_dr1, skid_dr2, main_dr1_in, main_dr2_in;

  assign o_valid  = (state_q != EMPTY);
  assign o_ready  = (state_q != FULL);
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (i_flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          main_load = 1'b1;
          state_d   = BUSY;
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: if (i_ready) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
          state_d        = BUSY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : i_ctrl;
  assign main_wa_in   = main_from_skid ? skid_wa   : i_wA;
  assign main_dr1_in  = main_from_skid ? skid_dr1  : i_DR1;
  assign main_dr2_in  = main_from_skid ? skid_dr2  : i_DR2;

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_main (
    .clk        (clk),
    .clr_all_i  (rst),
    .load_i     (main_load),
    .clr_ctrl_i (main_clr),
    .ctrl_i     (main_ctrl_in),
    .wa_i       (main_wa_in),
    .dr1_i      (main_dr1_in),
    .dr2_i      (main_dr2_in),
    .ctrl_o     (o_ctrl),
    .wa_o       (o_wA),
    .dr1_o      (o_DR1),
    .dr2_o      (o_DR2)
  );

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) u_skid (
    .clk        (clk),
    .clr_all_i  (rst),
    .load_i     (skid_load),
    .clr_ctrl_i (skid_clr),
    .ctrl_i     (i_ctrl),
    .wa_i       (i_wA),
    .dr1_i      (i_DR1),
    .dr2_i      (i_DR2),
    .ctrl_o     (skid_ctrl),
    .wa_o       (skid_wa),
    .dr1_o      (skid_dr1),
    .dr2_o      (skid_dr2)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_q, bubble_q;

  // A bubble is counted only when the flush throws away a held entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (o_valid && !i_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (i_flush && o_valid && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
    end
  end

  assign o_stall_cnt  = stall_q;
  assign o_bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised and directed bench for pipe_stage_buf against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 8;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] dr1;
    logic [DATA_W-1:0] dr2;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst, i_flush, i_valid, i_ready;
  logic              o_ready, o_valid;
  logic [CTRL_W-1:0] i_ctrl, o_ctrl;
  logic [ADDR_W-1:0] i_wA, o_wA;
  logic [DATA_W-1:0] i_DR1, i_DR2, o_DR1, o_DR2;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]       o_stall_cnt, o_bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  entry_t m_q[$];
  entry_t m_last;
  int     m_stall, m_bubble;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_ctrl  (i_ctrl),
    .i_wA    (i_wA),
    .i_DR1   (i_DR1),
    .i_DR2   (i_DR2),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_ctrl  (o_ctrl),
    .o_wA    (o_wA),
    .o_DR1   (o_DR1),
    .o_DR2   (o_DR2)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .o_stall_cnt  (o_stall_cnt),
    .o_bubble_cnt (o_bubble_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: FIFO of up to two held entries; outputs show the head.
  task automatic model_step();
    entry_t e;
    if (rst) begin
      m_q.delete();
      m_last   = '0;
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (m_q.size() > 0 && !i_ready && m_stall < 65535) m_stall++;
      if (i_flush) begin
        if (m_q.size() > 0 && m_bubble < 65535) m_bubble++;
        m_q.delete();
      end else begin
        bit accept, pop;
        accept = i_valid && (m_q.size() < 2);
        pop    = (m_q.size() > 0) && i_ready;
        if (pop) void'(m_q.pop_front());
        if (accept) begin
          e.ctrl = i_ctrl; e.wa = i_wA; e.dr1 = i_DR1; e.dr2 = i_DR2;
          m_q.push_back(e);
        end
      end
      if (m_q.size() > 0) m_last = m_q[0];
    end
  endtask

  task automatic check_outputs();
    chk("valid", {63'd0, o_valid}, {63'd0, m_q.size() > 0});
    chk("ready", {63'd0, o_ready}, {63'd0, m_q.size() < 2});
    chk("ctrl",  64'(o_ctrl), (m_q.size() > 0) ? 64'(m_last.ctrl) : 64'd0);
    chk("wA",    64'(o_wA),  64'(m_last.wa));
    chk("DR1",   64'(o_DR1), 64'(m_last.dr1));
    chk("DR2",   64'(o_DR2), 64'(m_last.dr2));
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt",  64'(o_stall_cnt),  64'(m_stall));
    chk("bubble_cnt", 64'(o_bubble_cnt), 64'(m_bubble));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    rst = 0; i_flush = 0; i_valid = 0; i_ready = 1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d1);
    i_valid = v; i_ctrl = c; i_DR1 = d1;
    i_wA = ADDR_W'($urandom); i_DR2 = $urandom;
  endtask

  initial begin
    rst = 1; i_flush = 0; i_valid = 1; i_ready = 0;
    i_ctrl = 8'hFF; i_wA = '1; i_DR1 = 32'h1234; i_DR2 = 32'h5678;
    m_last = '0; m_stall = 0; m_bubble = 0;
    @(negedge clk);

    // Reset held two cycles with a live input offered
    tick(); tick();
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_ctrl",  64'(o_ctrl), 64'd0);
    chk("rst_DR1",   64'(o_DR1),  64'd0);

    // Streaming 1..10 with downstream always ready
    idle();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 8'(i), i);
      tick();
      chk("stream_DR1", 64'(o_DR1), 64'(i));
    end
    idle(); tick();

    // Back-pressure: A then B held, then drained in order
    i_ready = 0;
    drive(1'b1, 8'h01, 32'hA); tick();
    drive(1'b1, 8'h02, 32'hB); tick();
    chk("bp_ready", {63'd0, o_ready}, 64'd0);
    chk("bp_DR1_A", 64'(o_DR1), 64'hA);
    i_valid = 0; i_ready = 1; tick();
    chk("bp_DR1_B", 64'(o_DR1), 64'hB);
    tick();
    chk("bp_drained", {63'd0, o_valid}, 64'd0);

    // Flush while FULL with C offered
    i_ready = 0;
    drive(1'b1, 8'h03, 32'hA); tick();
    drive(1'b1, 8'h04, 32'hB); tick();
    i_flush = 1; drive(1'b1, 8'h05, 32'hC); tick();
    chk("flush_valid", {63'd0, o_valid}, 64'd0);
    chk("flush_ctrl",  64'(o_ctrl), 64'd0);
    i_flush = 0; i_valid = 0; i_ready = 1; tick();
    chk("flush_noC", {63'd0, (o_valid && o_DR1 == 32'hC)}, 64'd0);

    // Bubble gating: ctrl must drop with valid
    drive(1'b1, 8'h0A, 32'h77); tick();
    chk("gate_ctrl_on", 64'(o_ctrl), 64'h0A);
    i_valid = 0; tick();
    chk("gate_valid", {63'd0, o_valid}, 64'd0);
    chk("gate_ctrl_off", 64'(o_ctrl), 64'd0);

`ifdef PIPE_STAGE_PERF_EN
    rst = 1; tick(); rst = 0;
    i_ready = 0; drive(1'b1, 8'h11, 32'h99); tick();
    i_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("perf_stall", 64'(o_stall_cnt), 64'd5);
    i_ready = 1; i_flush = 1; tick(); i_flush = 0;
    chk("perf_bubble", 64'(o_bubble_cnt), 64'd1);
`endif

    // Mid-transfer reset discards both slots
    i_ready = 0;
    drive(1'b1, 8'h21, 32'h5); tick();
    drive(1'b1, 8'h22, 32'h6); tick();
    rst = 1; i_flush = 1; tick();
    chk("midrst_valid", {63'd0, o_valid}, 64'd0);
    chk("midrst_DR1", 64'(o_DR1), 64'd0);
    idle();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      i_flush = ($urandom_range(0, 29) == 0);
      i_ready = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
